// File: rtl/character_anim_ctrl.sv
// Per-player animation/motion sequencer: state, frame index and x position for the sprite renderer.
// Optional CHAR_ANIM_COMBO_EN: holding the attack key at the end of an attack restarts it directly.
module character_anim_ctrl #(
  parameter int          TICKS_PER_FRAME = 4,
  parameter int          N_STAND   = 9,
  parameter int          N_FWD     = 10,
  parameter int          N_BWD     = 9,
  parameter int          N_ATTACK  = 6,
  parameter int          N_DEFENSE = 1,
  parameter int          N_HURT    = 5,
  parameter int          ACT_FIRST = 2,
  parameter int          ACT_LAST  = 3,
  parameter logic [18:0] START_X   = 19'd100,
  parameter logic [18:0] X_MIN     = 19'd0,
  parameter logic [18:0] STEP      = 19'd4,
  parameter logic [18:0] MIN_GAP   = 19'd80,
  parameter logic [7:0]  KEY_LEFT  = 8'h04,
  parameter logic [7:0]  KEY_RIGHT = 8'h07,
  parameter logic [7:0]  KEY_ATK   = 8'h0D,
  parameter logic [7:0]  KEY_DEF   = 8'h0E
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic        hit_in,
  input  logic [18:0] opponent_x,
  output logic [7:0]  character_state,
  output logic [7:0]  frame_num,
  output logic [18:0] character_x,
  output logic        attack_active
);
  localparam logic [7:0] ST_STAND = 8'd0, ST_ATK = 8'd1, ST_MOVL = 8'd2,
                         ST_MOVR  = 8'd3, ST_DEF = 8'd4, ST_HURT = 8'd5;
  localparam int CW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  logic [2:0]    sync_pipe;
  logic          tick;
  logic [CW-1:0] tick_cnt, cnt_nxt;
  logic          hit_pend, hp_nxt;
  logic [7:0]    st_nxt, fr_nxt, key_st, n_cur;
  logic [18:0]   x_nxt;
  logic          act_nxt, wrap, shielded;
  logic [20:0]   x_wide;

  function automatic logic [7:0] n_frames(input logic [7:0] s);
    case (s)
      ST_ATK:  return 8'(N_ATTACK);
      ST_MOVL: return 8'(N_BWD);
      ST_MOVR: return 8'(N_FWD);
      ST_DEF:  return 8'(N_DEFENSE);
      ST_HURT: return 8'(N_HURT);
      default: return 8'(N_STAND);
    endcase
  endfunction

  // Tick is registered so outputs move three edges after frame_clk is first seen high.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_pipe <= '0;
      tick      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], frame_clk};
      tick      <= sync_pipe[1] & ~sync_pipe[2];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      character_state <= ST_STAND;
      frame_num       <= 8'd0;
      tick_cnt        <= '0;
      hit_pend        <= 1'b0;
      character_x     <= START_X;
      attack_active   <= 1'b0;
    end else begin
      character_state <= st_nxt;
      frame_num       <= fr_nxt;
      tick_cnt        <= cnt_nxt;
      hit_pend        <= hp_nxt;
      character_x     <= x_nxt;
      attack_active   <= act_nxt;
    end
  end

  always_comb begin
    case (keycode)
      KEY_ATK:   key_st = ST_ATK;
      KEY_DEF:   key_st = ST_DEF;
      KEY_LEFT:  key_st = ST_MOVL;
      KEY_RIGHT: key_st = ST_MOVR;
      default:   key_st = ST_STAND;
    endcase
  end

  // Next-state: decisions only on tick; hits during defense/hurt never latch.
  always_comb begin
    st_nxt   = character_state;
    fr_nxt   = frame_num;
    cnt_nxt  = tick_cnt;
    n_cur    = n_frames(character_state);
    wrap     = (tick_cnt == CW'(TICKS_PER_FRAME - 1));
    shielded = (character_state == ST_DEF) || (character_state == ST_HURT);
    hp_nxt   = tick ? (hit_in & ~shielded) : (hit_pend | (hit_in & ~shielded));
    if (tick) begin
      if (hit_pend && !shielded) begin
        st_nxt  = ST_HURT;
        fr_nxt  = 8'd0;
        cnt_nxt = '0;
      end else if (character_state == ST_ATK || character_state == ST_HURT) begin
        cnt_nxt = wrap ? '0 : tick_cnt + 1'b1;
        if (wrap) begin
          if (frame_num == n_cur - 8'd1) begin
`ifdef CHAR_ANIM_COMBO_EN
            st_nxt = (character_state == ST_ATK && keycode == KEY_ATK) ? ST_ATK : ST_STAND;
`else
            st_nxt = ST_STAND;
`endif
            fr_nxt = 8'd0;
          end else begin
            fr_nxt = frame_num + 8'd1;
          end
        end
      end else if (key_st != character_state) begin
        st_nxt  = key_st;
        fr_nxt  = 8'd0;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = wrap ? '0 : tick_cnt + 1'b1;
        if (wrap) fr_nxt = (frame_num == n_cur - 8'd1) ? 8'd0 : frame_num + 8'd1;
      end
    end
  end

  // Motion follows the post-decision state so the entry tick already moves.
  always_comb begin
    x_nxt   = character_x;
    x_wide  = {2'b00, character_x} + {2'b00, STEP} + {2'b00, MIN_GAP};
    act_nxt = (st_nxt == ST_ATK) && (fr_nxt >= 8'(ACT_FIRST)) && (fr_nxt <= 8'(ACT_LAST));
    if (tick && st_nxt == ST_MOVL)
      x_nxt = ({2'b00, character_x} >= {2'b00, X_MIN} + {2'b00, STEP}) ? character_x - STEP : X_MIN;
    else if (tick && st_nxt == ST_MOVR && x_wide <= {2'b00, opponent_x})
      x_nxt = character_x + STEP;
  end
endmodule
